// File: rtl/m_axi_wr_master_if.sv
// Bus bundle for the single-beat AXI write master: command intake,
// the AW/W/B channels toward the slave, and completion status.
interface m_axi_wr_master_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  localparam int STRB_W = DATA_W / 8;

  // command side
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [ID_W-1:0]   cmd_id_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_data_i;
  logic [STRB_W-1:0] cmd_strb_i;

  // AXI write-address channel
  logic [ID_W-1:0]   awid_o;
  logic [ADDR_W-1:0] awaddr_o;
  logic              awvalid_o;
  logic              awready_i;

  // AXI write-data channel (single beat)
  logic [DATA_W-1:0] wdata_o;
  logic [STRB_W-1:0] wstrb_o;
  logic              wvalid_o;
  logic              wready_i;

  // AXI write-response channel
  logic [ID_W-1:0]   bid_i;
  logic [1:0]        bresp_i;
  logic              bvalid_i;
  logic              bready_o;

  // completion status
  logic              done_o;
  logic [1:0]        done_resp_o;
  logic              err_o;
  logic [15:0]       wr_count_o;
  logic [15:0]       err_count_o;

  modport master (
    input  cmd_valid_i, cmd_id_i, cmd_addr_i, cmd_data_i, cmd_strb_i,
    output cmd_ready_o,
    output awid_o, awaddr_o, awvalid_o,
    input  awready_i,
    output wdata_o, wstrb_o, wvalid_o,
    input  wready_i,
    input  bid_i, bresp_i, bvalid_i,
    output bready_o,
    output done_o, done_resp_o, err_o, wr_count_o, err_count_o
  );

  modport slave (
    output cmd_valid_i, cmd_id_i, cmd_addr_i, cmd_data_i, cmd_strb_i,
    input  cmd_ready_o,
    input  awid_o, awaddr_o, awvalid_o,
    output awready_i,
    input  wdata_o, wstrb_o, wvalid_o,
    output wready_i,
    output bid_i, bresp_i, bvalid_i,
    input  bready_o,
    input  done_o, done_resp_o, err_o, wr_count_o, err_count_o
  );

endinterface

// File: rtl/m_axi_wr_master.sv
// Single-outstanding AXI write master. A command is latched in IDLE,
// AW and W are offered together and retire independently, then the
// B response is collected and reported as a one-cycle done pulse with
// response, error flag and saturating completion/error counters.
module m_axi_wr_master #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              areset,
  m_axi_wr_master_if.master bus
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_n;

  logic              aw_vld_q, aw_vld_n;
  logic              w_vld_q, w_vld_n;
  logic              b_rdy_q, b_rdy_n;
  logic              cmd_rdy_q, cmd_rdy_n;
  logic              done_q, done_n;
  logic              err_q, err_n;
  logic [1:0]        resp_q, resp_n;
  logic [15:0]       wr_cnt_q, wr_cnt_n;
  logic [15:0]       err_cnt_q, err_cnt_n;
  logic              latch_cmd;

  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [STRB_W-1:0] strb_q;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Response is an error if not OKAY or if it answers a different ID.
  function automatic logic resp_is_err(input logic [1:0] resp,
                                       input logic [ID_W-1:0] bid,
                                       input logic [ID_W-1:0] id);
    return (resp != 2'b00) || (bid != id);
  endfunction

  // Next-state and next-output decode for the transaction sequencer.
  always_comb begin
    state_n   = state_q;
    aw_vld_n  = aw_vld_q;
    w_vld_n   = w_vld_q;
    b_rdy_n   = b_rdy_q;
    done_n    = 1'b0;
    err_n     = 1'b0;
    resp_n    = resp_q;
    wr_cnt_n  = wr_cnt_q;
    err_cnt_n = err_cnt_q;
    latch_cmd = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i && cmd_rdy_q) begin
          latch_cmd = 1'b1;
          aw_vld_n  = 1'b1;
          w_vld_n   = 1'b1;
          state_n   = XFER;
        end
      end
      XFER: begin
        // each channel retires on its own handshake; order is free
        if (aw_vld_q && bus.awready_i) aw_vld_n = 1'b0;
        if (w_vld_q && bus.wready_i)   w_vld_n  = 1'b0;
        if (!aw_vld_n && !w_vld_n) begin
          state_n = RESP;
          b_rdy_n = 1'b1;
        end
      end
      RESP: begin
        if (b_rdy_q && bus.bvalid_i) begin
          b_rdy_n  = 1'b0;
          state_n  = IDLE;
          done_n   = 1'b1;
          resp_n   = bus.bresp_i;
          err_n    = resp_is_err(bus.bresp_i, bus.bid_i, id_q);
          wr_cnt_n = sat_inc(wr_cnt_q);
          if (err_n) err_cnt_n = sat_inc(err_cnt_q);
        end
      end
      default: begin
        state_n  = IDLE;
        aw_vld_n = 1'b0;
        w_vld_n  = 1'b0;
        b_rdy_n  = 1'b0;
      end
    endcase

    // ready is registered so it stays low through the reset cycle and
    // rises together with the done pulse on return to IDLE
    cmd_rdy_n = (state_n == IDLE);
  end

  // State, handshake flags, status and counters.
  always_ff @(posedge clk) begin
    if (!areset) begin
      state_q   <= IDLE;
      aw_vld_q  <= 1'b0;
      w_vld_q   <= 1'b0;
      b_rdy_q   <= 1'b0;
      cmd_rdy_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      resp_q    <= 2'b00;
      wr_cnt_q  <= 16'd0;
      err_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_n;
      aw_vld_q  <= aw_vld_n;
      w_vld_q   <= w_vld_n;
      b_rdy_q   <= b_rdy_n;
      cmd_rdy_q <= cmd_rdy_n;
      done_q    <= done_n;
      err_q     <= err_n;
      resp_q    <= resp_n;
      wr_cnt_q  <= wr_cnt_n;
      err_cnt_q <= err_cnt_n;
    end
  end

  // Command field capture; these drive the AW/W payload for the whole transaction.
  always_ff @(posedge clk) begin
    if (!areset) begin
      id_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
    end else if (latch_cmd) begin
      id_q   <= bus.cmd_id_i;
      addr_q <= bus.cmd_addr_i;
      data_q <= bus.cmd_data_i;
      strb_q <= bus.cmd_strb_i;
    end
  end

  assign bus.cmd_ready_o = cmd_rdy_q;
  assign bus.awid_o      = id_q;
  assign bus.awaddr_o    = addr_q;
  assign bus.awvalid_o   = aw_vld_q;
  assign bus.wdata_o     = data_q;
  assign bus.wstrb_o     = strb_q;
  assign bus.wvalid_o    = w_vld_q;
  assign bus.bready_o    = b_rdy_q;
  assign bus.done_o      = done_q;
  assign bus.done_resp_o = resp_q;
  assign bus.err_o       = err_q;
  assign bus.wr_count_o  = wr_cnt_q;
  assign bus.err_count_o = err_cnt_q;

endmodule

// File: tb/tb_m_axi_wr_master.sv
// Bench for m_axi_wr_master: directed and randomized single writes
// against a cycle-timing reference derived from the slave delays.
module tb_m_axi_wr_master;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  logic clk;
  logic areset;

  m_axi_wr_master_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  m_axi_wr_master #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  int         exp_wr   = 0;
  int         exp_err  = 0;
  logic [1:0] exp_resp = 2'b00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_counters();
    chk("wr_count", 64'(bus.wr_count_o), 64'(exp_wr));
    chk("err_count", 64'(bus.err_count_o), 64'(exp_err));
  endtask

  // One complete write. da/dw: cycles AW/W valid waits before ready;
  // db: cycles bready waits for bvalid; bhold keeps bvalid high throughout.
  // With all delays zero: accept at 0, AW/W at 1, bready at 2, done at 3.
  task automatic do_write(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data, input logic [STRB_W-1:0] strb,
                          input int da, input int dw, input int db,
                          input logic [1:0] bresp, input logic [ID_W-1:0] bid,
                          input logic bhold);
    int   m, dbe, td;
    logic err_exp;
    m       = (da > dw) ? da : dw;
    dbe     = bhold ? 0 : db;
    td      = 3 + m + dbe;
    err_exp = (bresp != 2'b00) || (bid != id);

    @(negedge clk);
    chk("idle_ready", 64'(bus.cmd_ready_o), 64'd1);
    chk("idle_done", 64'(bus.done_o), 64'd0);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_id_i    = id;
    bus.cmd_addr_i  = addr;
    bus.cmd_data_i  = data;
    bus.cmd_strb_i  = strb;
    bus.awready_i   = 1'b0;
    bus.wready_i    = 1'b0;
    bus.bvalid_i    = bhold;
    bus.bresp_i     = bhold ? bresp : 2'($urandom);
    bus.bid_i       = bhold ? bid : ID_W'($urandom);

    for (int t = 1; t <= td; t++) begin
      @(negedge clk);
      // scramble command inputs: outputs must come from latched copies
      bus.cmd_valid_i = 1'b0;
      bus.cmd_id_i    = ID_W'($urandom);
      bus.cmd_addr_i  = ADDR_W'($urandom);
      bus.cmd_data_i  = DATA_W'($urandom);
      bus.cmd_strb_i  = STRB_W'($urandom);

      if (t == td) begin
        exp_wr = (exp_wr < 65535) ? exp_wr + 1 : exp_wr;
        if (err_exp) exp_err = (exp_err < 65535) ? exp_err + 1 : exp_err;
        exp_resp = bresp;
      end

      chk("awvalid", 64'(bus.awvalid_o), 64'(t <= 1 + da));
      chk("wvalid", 64'(bus.wvalid_o), 64'(t <= 1 + dw));
      if (t <= 1 + da) begin
        chk("awid", 64'(bus.awid_o), 64'(id));
        chk("awaddr", 64'(bus.awaddr_o), 64'(addr));
      end
      if (t <= 1 + dw) begin
        chk("wdata", 64'(bus.wdata_o), 64'(data));
        chk("wstrb", 64'(bus.wstrb_o), 64'(strb));
      end
      chk("bready", 64'(bus.bready_o), 64'((t >= 2 + m) && (t < td)));
      chk("done", 64'(bus.done_o), 64'(t == td));
      chk("cmd_ready", 64'(bus.cmd_ready_o), 64'(t == td));
      chk("err", 64'(bus.err_o), 64'((t == td) ? err_exp : 1'b0));
      chk("done_resp", 64'(bus.done_resp_o), 64'(exp_resp));
      chk_counters();

      // slave drive for the edge that ends cycle t
      if (t < 1 + da)       bus.awready_i = 1'b0;
      else if (t == 1 + da) bus.awready_i = 1'b1;
      else                  bus.awready_i = 1'($urandom);
      if (t < 1 + dw)       bus.wready_i = 1'b0;
      else if (t == 1 + dw) bus.wready_i = 1'b1;
      else                  bus.wready_i = 1'($urandom);

      if (bhold) begin
        bus.bvalid_i = 1'b1;
        bus.bresp_i  = bresp;
        bus.bid_i    = bid;
      end else if (t < 2 + m) begin
        bus.bvalid_i = 1'($urandom);
        bus.bresp_i  = 2'($urandom);
        bus.bid_i    = ID_W'($urandom);
      end else begin
        bus.bvalid_i = (t == 2 + m + dbe);
        bus.bresp_i  = bresp;
        bus.bid_i    = bid;
      end
    end
    if (!bhold) bus.bvalid_i = 1'b0;
  endtask

  initial begin
    areset          = 1'b0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_id_i    = '0;
    bus.cmd_addr_i  = '0;
    bus.cmd_data_i  = '0;
    bus.cmd_strb_i  = '0;
    bus.awready_i   = 1'b0;
    bus.wready_i    = 1'b0;
    bus.bid_i       = '0;
    bus.bresp_i     = 2'b00;
    bus.bvalid_i    = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
    chk("rst_awvalid", 64'(bus.awvalid_o), 64'd0);
    chk("rst_wvalid", 64'(bus.wvalid_o), 64'd0);
    chk("rst_bready", 64'(bus.bready_o), 64'd0);
    chk("rst_done", 64'(bus.done_o), 64'd0);
    chk("rst_err", 64'(bus.err_o), 64'd0);
    chk("rst_resp", 64'(bus.done_resp_o), 64'd0);
    chk("rst_awaddr", 64'(bus.awaddr_o), 64'd0);
    chk("rst_wdata", 64'(bus.wdata_o), 64'd0);
    chk_counters();
    areset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.cmd_ready_o), 64'd1);

    // minimum-latency single write
    do_write(4'd3, 32'h1, 32'hABCDEFAC, 4'b1010, 0, 0, 0, 2'b00, 4'd3, 1'b0);
    chk("single_wr_count", 64'(bus.wr_count_o), 64'd1);

    // AW ready late, W immediate; then the reverse
    do_write(4'd7, 32'h1000_0040, 32'h1234_5678, 4'b1111, 4, 0, 0, 2'b00, 4'd7, 1'b0);
    do_write(4'd2, 32'h2000_0000, 32'hCAFE_F00D, 4'b0011, 0, 3, 2, 2'b00, 4'd2, 1'b0);

    // SLVERR, then OKAY with mismatched ID
    do_write(4'd1, 32'h44, 32'h5555_AAAA, 4'b1111, 1, 1, 1, 2'b10, 4'd1, 1'b0);
    chk("slverr_resp", 64'(bus.done_resp_o), 64'd2);
    chk("slverr_cnt", 64'(bus.err_count_o), 64'd1);
    do_write(4'd4, 32'h48, 32'h0F0F_0F0F, 4'b0101, 0, 0, 0, 2'b00, 4'd9, 1'b0);
    chk("bid_err_cnt", 64'(bus.err_count_o), 64'd2);

    // reset in the middle of XFER with a late bvalid
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_id_i    = 4'd5;
    bus.cmd_addr_i  = 32'hDEAD_0000;
    bus.cmd_data_i  = 32'h0BAD_0BAD;
    bus.cmd_strb_i  = 4'hF;
    bus.awready_i   = 1'b0;
    bus.wready_i    = 1'b0;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    chk("mid_awvalid", 64'(bus.awvalid_o), 64'd1);
    areset       = 1'b0;
    bus.bvalid_i = 1'b1;
    bus.bresp_i  = 2'b00;
    bus.bid_i    = 4'd5;
    @(negedge clk);
    exp_wr   = 0;
    exp_err  = 0;
    exp_resp = 2'b00;
    chk("mid_rst_awvalid", 64'(bus.awvalid_o), 64'd0);
    chk("mid_rst_wvalid", 64'(bus.wvalid_o), 64'd0);
    chk("mid_rst_bready", 64'(bus.bready_o), 64'd0);
    chk("mid_rst_done", 64'(bus.done_o), 64'd0);
    chk("mid_rst_ready", 64'(bus.cmd_ready_o), 64'd0);
    chk("mid_rst_awaddr", 64'(bus.awaddr_o), 64'd0);
    chk_counters();
    areset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_b_done", 64'(bus.done_o), 64'd0);
      chk("late_b_bready", 64'(bus.bready_o), 64'd0);
      chk_counters();
    end
    bus.bvalid_i = 1'b0;

    // bvalid held high throughout, ten commands
    for (int i = 0; i < 10; i++) begin
      logic [ID_W-1:0] id;
      id = ID_W'($urandom);
      do_write(id, ADDR_W'($urandom), DATA_W'($urandom), STRB_W'($urandom),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0,
               2'b00, id, 1'b1);
    end
    bus.bvalid_i = 1'b0;
    chk("b2b_wr_count", 64'(bus.wr_count_o), 64'd10);

    // randomized writes
    for (int i = 0; i < 25; i++) begin
      logic [ID_W-1:0] id, bid;
      logic [1:0]      resp;
      id   = ID_W'($urandom);
      bid  = ($urandom_range(0, 7) == 0) ? ID_W'(id + 1) : id;
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_write(id, ADDR_W'($urandom), DATA_W'($urandom), STRB_W'($urandom),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 3)), resp, bid, 1'b0);
    end
    @(negedge clk);
    chk("final_done", 64'(bus.done_o), 64'd0);
    chk_counters();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/m_axi_wr_master.md
M_AXI_WR_MASTER -- requirements
Module: m_axi_wr_master

Interface
REQ-001 The block SHALL have parameter ID_W, default 4, AXI ID width.
REQ-002 The block SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-003 The block SHALL have parameter DATA_W, default 32, AXI data width; strobe width is DATA_W/8.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset; all state changes on rising clk.
REQ-005 clk  in  1  clock.
REQ-006 areset  in  1  synchronous active-low reset.
REQ-007 cmd_valid_i / cmd_ready_o  in / out  1 / 1  command handshake.
REQ-008 cmd_id_i, cmd_addr_i, cmd_data_i, cmd_strb_i  in  ID_W, ADDR_W, DATA_W, DATA_W/8  write command fields.
REQ-009 awid_o, awaddr_o, awvalid_o / awready_i  out, out, out / in  ID_W, ADDR_W, 1 / 1  AXI write-address channel.
REQ-010 wdata_o, wstrb_o, wvalid_o / wready_i  out, out, out / in  DATA_W, DATA_W/8, 1 / 1  AXI write-data channel (single beat).
REQ-011 bid_i, bresp_i, bvalid_i / bready_o  in, in, in / out  ID_W, 2, 1 / 1  AXI write-response channel.
REQ-012 done_o, done_resp_o, err_o  out  1, 2, 1  completion pulse, captured bresp, error flag.
REQ-013 wr_count_o, err_count_o  out  16, 16  completed-write and error counters.

Function
REQ-014 FSM states SHALL be IDLE, XFER, RESP; cmd_ready_o SHALL be 1 only in IDLE.
REQ-015 On cmd_valid_i & cmd_ready_o, the block SHALL latch all command fields, enter XFER, and drive awvalid_o=1 and wvalid_o=1 from the next cycle.
REQ-016 awid_o/awaddr_o and wdata_o/wstrb_o SHALL be stable, from latched registers, while the matching valid is high.
REQ-017 awvalid_o SHALL drop the cycle after awready_i is sampled high with awvalid_o=1; wvalid_o likewise with wready_i; the channels complete independently in either order or the same cycle.
REQ-018 When both AW and W handshakes have completed, the block SHALL enter RESP and drive bready_o=1 from the next cycle.
REQ-019 bvalid_i while bready_o=0, including during XFER or IDLE, SHALL be ignored.
REQ-020 On bvalid_i & bready_o in RESP, the block SHALL deassert bready_o, return to IDLE, and pulse done_o for exactly one cycle on the following cycle, with done_resp_o=bresp_i captured.
REQ-021 cmd_ready_o SHALL be high in the same cycle as the done_o pulse; done_resp_o holds until the next completion.
REQ-022 err_o SHALL be 1 with done_o when bresp_i!=2'b00 or bid_i!=latched ID; otherwise 0.
REQ-023 wr_count_o SHALL increment on every completion; err_count_o SHALL increment when err_o=1; both SHALL saturate at 16'hFFFF.
REQ-024 Minimum latency with all slave readies and bvalid_i tied high: accept at cycle 0, AW/W valid and handshake at 1, bready at 2, done_o at 3.
REQ-025 The block SHALL have at most one outstanding transaction; new commands are not accepted until done_o.

Reset
REQ-026 While areset=0 at a rising edge, the block SHALL set state=IDLE, awvalid_o=wvalid_o=bready_o=0, done_o=err_o=0, done_resp_o=0, both counters=0, cmd_ready_o=0, and all address/data/ID outputs=0.
REQ-027 cmd_ready_o SHALL go to 1 on the first cycle with areset=1.
REQ-028 Reset asserted mid-transaction SHALL abandon it with no done_o pulse and no counter update; a late bvalid_i SHALL be ignored.

Verification
REQ-029 Single write, slave readies high: cmd id=3, addr=0x1, data=0xABCDEFAC, strb=4'b1010 -> AW/W carry these values, done_o at cycle 3, done_resp_o=0, err_o=0, wr_count_o=1.
REQ-030 awready_i delayed 4 cycles, wready_i immediate -> wvalid_o drops after 1 cycle; awvalid_o and awaddr_o are held stable 4 cycles; bready_o rises only after the AW handshake.
REQ-031 bresp_i=2'b10 -> err_o=1, done_resp_o=2'b10, err_count_o=1; then bid_i mismatch with OKAY -> err_o=1, err_count_o=2.
REQ-032 bvalid_i held high from cmd accept -> ignored until RESP; exactly one done_o per command; 10 back-to-back commands give wr_count_o=10.
REQ-033 areset=0 for one cycle while in XFER -> all valids 0 next cycle, counters 0, no done_o; the next command completes normally.
